// File: rtl/assoc_cache_wb.sv
// N-way set-associative write-back/write-allocate cache, true-LRU; optional stats via CACHE_STATS_EN.
// Hit completes 2 cycles after the req edge; misses wait on mem_ack; cpu_req while busy is dropped.
module assoc_cache_wb #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int NUM_SETS = 2,
   parameter int NUM_WAYS = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_busy,
   output logic              hit,
   output logic              mem_req,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [2:0]        state,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - SET_W;
   localparam int AGE_W = $clog2(NUM_WAYS);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      WRITEBACK = 3'd2,
      REFILL    = 3'd3
   } state_t;

   state_t state_q, state_d;

   logic              valid_q [NUM_SETS][NUM_WAYS];
   logic              valid_d [NUM_SETS][NUM_WAYS];
   logic              dirty_q [NUM_SETS][NUM_WAYS];
   logic              dirty_d [NUM_SETS][NUM_WAYS];
   logic [AGE_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];
   logic [AGE_W-1:0]  age_d   [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]  tag_d   [NUM_SETS][NUM_WAYS];
   logic [DATA_W-1:0] data_q  [NUM_SETS][NUM_WAYS];
   logic [DATA_W-1:0] data_d  [NUM_SETS][NUM_WAYS];

   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [AGE_W-1:0]  victim_q, victim_d;
   logic              mem_req_q, mem_req_d;
   logic              cpu_done_q, cpu_done_d;
   logic              hit_q, hit_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

   logic [SET_W-1:0]  set_idx;
   logic [TAG_W-1:0]  tag_in;
   logic              hit_any;
   logic [AGE_W-1:0]  hit_way;
   logic              inv_found;
   logic [AGE_W-1:0]  vict_way;
   logic              touch;
   logic [AGE_W-1:0]  touch_way;
   logic [AGE_W-1:0]  touch_age;

   assign set_idx = addr_q[SET_W-1:0];
   assign tag_in  = addr_q[ADDR_W-1:SET_W];

   // Tag match and victim choice: first invalid way wins, otherwise the LRU way.
   always_comb begin
      hit_any   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      vict_way  = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
            hit_any = 1'b1;
            hit_way = AGE_W'(w);
         end
         if (!inv_found && !valid_q[set_idx][w]) begin
            inv_found = 1'b1;
            vict_way  = AGE_W'(w);
         end
      end
      if (!inv_found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[set_idx][w] == AGE_W'(NUM_WAYS - 1)) begin
               vict_way = AGE_W'(w);
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      age_d       = age_q;
      tag_d       = tag_q;
      data_d      = data_q;
      wren_d      = wren_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      victim_d    = victim_q;
      mem_req_d   = mem_req_q;
      cpu_done_d  = 1'b0;
      hit_d       = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      touch       = 1'b0;
      touch_way   = '0;
      touch_age   = '0;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               wren_d  = cpu_wren;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit_any) begin
               touch     = 1'b1;
               touch_way = hit_way;
               if (wren_q) begin
                  data_d[set_idx][hit_way]  = wdata_q;
                  dirty_d[set_idx][hit_way] = 1'b1;
                  cpu_rdata_d               = wdata_q;
               end else begin
                  cpu_rdata_d = data_q[set_idx][hit_way];
               end
               cpu_done_d = 1'b1;
               hit_d      = 1'b1;
               state_d    = IDLE;
            end else begin
               victim_d  = vict_way;
               mem_req_d = 1'b1;
               if (valid_q[set_idx][vict_way] && dirty_q[set_idx][vict_way]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = REFILL;
               end
            end
         end
         WRITEBACK: begin
            if (mem_req_q && mem_ack) begin
               dirty_d[set_idx][victim_q] = 1'b0;
               mem_req_d                  = 1'b0;
               state_d                    = REFILL;
            end
         end
         REFILL: begin
            // Arriving from WRITEBACK, mem_req is low for one cycle before the refill read.
            if (!mem_req_q) begin
               mem_req_d = 1'b1;
            end else if (mem_ack) begin
               tag_d[set_idx][victim_q]   = tag_in;
               valid_d[set_idx][victim_q] = 1'b1;
               if (wren_q) begin
                  data_d[set_idx][victim_q]  = wdata_q;
                  dirty_d[set_idx][victim_q] = 1'b1;
                  cpu_rdata_d                = wdata_q;
               end else begin
                  data_d[set_idx][victim_q]  = mem_rdata;
                  dirty_d[set_idx][victim_q] = 1'b0;
                  cpu_rdata_d                = mem_rdata;
               end
               touch      = 1'b1;
               touch_way  = victim_q;
               cpu_done_d = 1'b1;
               mem_req_d  = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase

      if (touch) begin
         touch_age = age_q[set_idx][touch_way];
         for (int j = 0; j < NUM_WAYS; j++) begin
            if (age_q[set_idx][j] < touch_age) begin
               age_d[set_idx][j] = age_q[set_idx][j] + AGE_W'(1);
            end
         end
         age_d[set_idx][touch_way] = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wren_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         victim_q    <= '0;
         mem_req_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
         hit_q       <= 1'b0;
         cpu_rdata_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= AGE_W'(w);
               tag_q[s][w]   <= '0;
               data_q[s][w]  <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         wren_q      <= wren_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         victim_q    <= victim_d;
         mem_req_q   <= mem_req_d;
         cpu_done_q  <= cpu_done_d;
         hit_q       <= hit_d;
         cpu_rdata_q <= cpu_rdata_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         age_q       <= age_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
      end
   end

   assign state     = state_q;
   assign cpu_busy  = (state_q != IDLE);
   assign cpu_done  = cpu_done_q;
   assign hit       = hit_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_wren  = (state_q == WRITEBACK);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == WRITEBACK) begin
         mem_addr  = {tag_q[set_idx][victim_q], set_idx};
         mem_wdata = data_q[set_idx][victim_q];
      end else if (state_q == REFILL) begin
         mem_addr = addr_q;
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_count_q, hit_count_d;
   logic [15:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (cpu_done_d && hit_d && (hit_count_q != 16'hFFFF)) begin
         hit_count_d = hit_count_q + 16'd1;
      end
      if (cpu_done_d && !hit_d && (miss_count_q != 16'hFFFF)) begin
         miss_count_d = miss_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   assign hit_count  = 16'h0000;
   assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Bench for assoc_cache_wb: table of CPU accesses against a RAM model, scoreboard of expected completions.
module tb_assoc_cache_wb;
   logic       clock = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_wren;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata, cpu_rdata;
   logic       cpu_done, cpu_busy, hit;
   logic       mem_req, mem_wren;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       mem_ack;
   logic [2:0] state;
   logic [15:0] hit_count, miss_count;

   always #5 clock = ~clock;

   assoc_cache_wb #(.ADDR_W(5), .DATA_W(8), .NUM_SETS(2), .NUM_WAYS(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy), .hit(hit),
      .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state(state),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct {
      bit         rst;
      bit         wr;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      bit         exp_hit;
      bit         exp_wb;
      logic [4:0] wb_addr;
      logic [7:0] wb_data;
      int         dly;
      bit         poke;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      bit         hit;
   } exp_t;

   vec_t       vecs[$];
   exp_t       sb[$];
   logic [7:0] ram [32];
   int         n_checks = 0;
   int         n_fail = 0;
   int         exp_hits = 0;
   int         exp_misses = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, expv);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input int n);
`ifdef CACHE_STATS_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return 16'(n - n);
`endif
   endfunction

   function automatic vec_t mk(input bit rst, input bit wr, input logic [4:0] a, input logic [7:0] d,
                               input logic [7:0] rd, input bit h, input bit wb, input logic [4:0] wa,
                               input logic [7:0] wd, input int dly, input bit poke);
      vec_t v;
      v.rst = rst; v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = rd; v.exp_hit = h;
      v.exp_wb = wb; v.wb_addr = wa; v.wb_data = wd; v.dly = dly; v.poke = poke;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
   endtask

   task automatic access(input vec_t v, input int idx);
      int         cyc, wb_n, rf_n, wait_n;
      bit         done, prev_req;
      logic [4:0] cap_addr, wb_a;
      logic [7:0] cap_wdata, wb_d;
      exp_t       e, got;
      e.rdata = v.exp_rdata;
      e.hit   = v.exp_hit;
      sb.push_back(e);
      cpu_req = 1'b1; cpu_wren = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
      @(negedge clock);
      // Scramble the CPU inputs: the request must already be latched.
      cpu_req = 1'b0; cpu_addr = 5'h1F; cpu_wdata = 8'hEE; cpu_wren = ~v.wr;
      cyc = 1; done = 1'b0; prev_req = 1'b0; wb_n = 0; rf_n = 0; wait_n = 0;
      cap_addr = '0; cap_wdata = '0; wb_a = '0; wb_d = '0;
      while (!done && cyc < 100) begin
         mem_ack = 1'b0;
         mem_rdata = 8'hC3;
         if (cpu_done) begin
            done = 1'b1;
            if (sb.size() == 0) begin
               chk("sb_underflow", idx, 1, 0);
            end else begin
               got = sb.pop_front();
               chk("rdata", idx, cpu_rdata, got.rdata);
               chk("hit", idx, hit, got.hit);
            end
            if (v.exp_hit) chk("hit_latency", idx, cyc, 2);
         end else if (mem_req) begin
            if (!prev_req) begin
               wait_n = 0;
               cap_addr = mem_addr;
               cap_wdata = mem_wdata;
               if (mem_wren) begin
                  wb_n++; wb_a = mem_addr; wb_d = mem_wdata;
               end else begin
                  rf_n++;
                  chk("refill_addr", idx, mem_addr, v.addr);
               end
            end else begin
               chk("mem_addr_stable", idx, mem_addr, cap_addr);
               if (mem_wren) chk("mem_wdata_stable", idx, mem_wdata, cap_wdata);
            end
            if (wait_n == v.dly) begin
               mem_ack = 1'b1;
               if (mem_wren) ram[mem_addr] = mem_wdata;
               else          mem_rdata = ram[mem_addr];
            end
            wait_n++;
         end
         prev_req = mem_req;
         cpu_req = v.poke && cpu_busy && !done;
         @(negedge clock);
         cyc++;
      end
      mem_ack = 1'b0;
      cpu_req = 1'b0;
      if (!done) begin
         chk("timeout", idx, 0, 1);
         sb.delete();
      end
      chk("wb_count", idx, wb_n, v.exp_wb ? 1 : 0);
      if (v.exp_wb) begin
         chk("wb_addr", idx, wb_a, v.wb_addr);
         chk("wb_data", idx, wb_d, v.wb_data);
      end
      chk("refill_count", idx, rf_n, v.exp_hit ? 0 : 1);
      chk("done_pulse", idx, cpu_done, 0);
      chk("idle_after", idx, state, 0);
      chk("mem_req_after", idx, mem_req, 0);
      if (v.exp_hit) exp_hits++;
      else           exp_misses++;
      @(negedge clock);
      chk("hit_count", idx, hit_count, exp_cnt(exp_hits));
      chk("miss_count", idx, miss_count, exp_cnt(exp_misses));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      int   t;
      for (int a = 0; a < 32; a++) ram[a] = 8'(a) ^ 8'h12;
      reset = 1'b1; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clock);
      chk("rst_state", 0, state, 0);
      chk("rst_busy", 0, cpu_busy, 0);
      chk("rst_done", 0, cpu_done, 0);
      chk("rst_hit", 0, hit, 0);
      chk("rst_rdata", 0, cpu_rdata, 0);
      chk("rst_mem_req", 0, mem_req, 0);
      chk("rst_mem_wren", 0, mem_wren, 0);
      chk("rst_mem_addr", 0, mem_addr, 0);
      chk("rst_hit_count", 0, hit_count, 0);
      chk("rst_miss_count", 0, miss_count, 0);
      reset = 1'b0;
      @(negedge clock);

      //             rst wr addr   wdata  rdata  hit wb wbaddr wbdata dly poke
      vecs.push_back(mk(0, 0, 5'h14, 8'h00, 8'h06, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h14, 8'h00, 8'h06, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 1, 5'h14, 8'hAB, 8'hAB, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h14, 8'h00, 8'hAB, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(1, 0, 5'h00, 8'h00, 8'h12, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h02, 8'h00, 8'h10, 0, 0, 5'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 5'h04, 8'h00, 8'h16, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h06, 8'h00, 8'h14, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 1, 5'h00, 8'h55, 8'h55, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h02, 8'h00, 8'h10, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h04, 8'h00, 8'h16, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h06, 8'h00, 8'h14, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h08, 8'h00, 8'h1A, 0, 1, 5'h00, 8'h55, 5, 1));
      vecs.push_back(mk(0, 0, 5'h00, 8'h00, 8'h55, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(1, 0, 5'h00, 8'h00, 8'h55, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h02, 8'h00, 8'h10, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h04, 8'h00, 8'h16, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h06, 8'h00, 8'h14, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h02, 8'h00, 8'h10, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h04, 8'h00, 8'h16, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h06, 8'h00, 8'h14, 1, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h08, 8'h00, 8'h1A, 0, 0, 5'h00, 8'h00, 2, 1));
      vecs.push_back(mk(0, 1, 5'h01, 8'h77, 8'h77, 0, 0, 5'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 5'h01, 8'h00, 8'h77, 1, 0, 5'h00, 8'h00, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         access(vecs[i], i);
      end

      // Reset while a refill is outstanding: request abandoned, line stays invalid.
      do_reset();
      cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 5'h16; cpu_wdata = 8'h00;
      @(negedge clock);
      cpu_req = 1'b0;
      t = 0;
      while (!mem_req && t < 10) begin
         @(negedge clock);
         t++;
      end
      chk("pre_rst_mem_req", 100, mem_req, 1);
      chk("pre_rst_state", 100, state, 3);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_mem_req", 100, mem_req, 0);
      chk("mid_rst_state", 100, state, 0);
      chk("mid_rst_busy", 100, cpu_busy, 0);
      @(negedge clock);
      reset = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
      chk("post_rst_hit_count", 100, hit_count, 0);
      chk("post_rst_miss_count", 100, miss_count, 0);
      @(negedge clock);
      rv = mk(0, 0, 5'h16, 8'h00, 8'h04, 0, 0, 5'h00, 8'h00, 0, 0);
      access(rv, 101);
      chk("sb_drained", 102, sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
